// File: rtl/alu_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_accum_seq
//  Description : Sequential 4-bit ALU with an 8-bit result register whose low
//                nibble feeds back as operand B. Single-cycle ops run in CALC;
//                multiply runs in MUL by repeated addition, one add per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_accum_seq (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] Data,
   input  logic [2:0] Function,
   input  logic       Go,
   output logic [7:0] ALUout,
   output logic       Busy,
   output logic       Done
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CALC = 2'd1;
   localparam logic [1:0] c_MUL  = 2'd2;

   localparam logic [2:0] c_OP_MUL  = 3'b110;

   logic [1:0] r_state;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic [2:0] r_f;
   logic [7:0] r_acc;
   logic [3:0] r_cnt;
   logic [7:0] r_aluout;
   logic       r_done;

   logic [4:0] w_sum;
   logic [7:0] w_calc;
   logic       w_write;

   // Single-cycle result for the latched operands; 111 (and the unreachable
   // 110 in CALC) leaves the result register untouched.
   always_comb begin
      w_sum   = {1'b0, r_a} + {1'b0, r_b};
      w_calc  = r_aluout;
      w_write = 1'b1;
      case (r_f)
         3'b000:  w_calc = {3'b000, w_sum};
         3'b001:  w_calc = {4'b0000, w_sum[3:0]};
         3'b010:  w_calc = {{4{r_b[3]}}, r_b};
         3'b011:  w_calc = {7'b0, |{r_a, r_b}};
         3'b100:  w_calc = {7'b0, &{r_a, r_b}};
         3'b101:  w_calc = {r_a, r_b};
         default: w_write = 1'b0;
      endcase
   end

   // Control FSM, operand latches, multiply accumulator and Done pulse.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= c_IDLE;
         r_a      <= 4'h0;
         r_b      <= 4'h0;
         r_f      <= 3'b000;
         r_acc    <= 8'h00;
         r_cnt    <= 4'h0;
         r_aluout <= 8'h00;
         r_done   <= 1'b0;
      end else begin
         // Done is a one-edge pulse; only a completing edge sets it again.
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (Go) begin
                  r_a <= Data;
                  r_f <= Function;
                  r_b <= r_aluout[3:0];
                  if (Function == c_OP_MUL) begin
                     r_acc   <= 8'h00;
                     r_cnt   <= r_aluout[3:0];
                     r_state <= c_MUL;
                  end else begin
                     r_state <= c_CALC;
                  end
               end
            end
            c_CALC: begin
               if (w_write) begin
                  r_aluout <= w_calc;
               end
               r_done  <= 1'b1;
               r_state <= c_IDLE;
            end
            c_MUL: begin
               if (r_cnt != 4'h0) begin
                  r_acc <= r_acc + {4'h0, r_a};
                  r_cnt <= r_cnt - 4'h1;
               end else begin
                  r_aluout <= r_acc;
                  r_done   <= 1'b1;
                  r_state  <= c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign ALUout = r_aluout;
   assign Done   = r_done;
   assign Busy   = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_accum_seq
//  Description : Self-checking bench for alu_accum_seq: an operation-level
//                model predicts ALUout/Busy/Done each cycle, and directed
//                sequences pin the model with hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accum_seq;

   logic       Clock;
   logic       Reset;
   logic [3:0] Data;
   logic [2:0] Function;
   logic       Go;
   logic [7:0] ALUout;
   logic       Busy;
   logic       Done;

   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 0;

   alu_accum_seq dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Data     (Data),
      .Function (Function),
      .Go       (Go),
      .ALUout   (ALUout),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // ---------------- operation-level model ----------------
   // At acceptance the final result and its latency (edges until write) are
   // computed outright; the model then just counts edges down.
   int         m_rem;
   logic [7:0] m_alu;
   logic [7:0] m_pending;
   bit         m_keep;
   bit         m_done;

   always @(posedge Clock) begin
      int a, b, s;
      if (Reset) begin
         m_rem  = 0;
         m_alu  = 8'h00;
         m_done = 0;
      end else if (m_rem > 0) begin
         m_done = 0;
         m_rem--;
         if (m_rem == 0) begin
            if (!m_keep) m_alu = m_pending;
            m_done = 1;
         end
      end else begin
         m_done = 0;
         if (Go === 1'b1) begin
            a = int'(Data);
            b = int'(m_alu[3:0]);
            s = a + b;
            m_keep = 0;
            m_rem  = 1;
            case (Function)
               3'd0: m_pending = 8'(s);
               3'd1: m_pending = 8'(s % 16);
               3'd2: m_pending = (b >= 8) ? 8'(b + 240) : 8'(b);
               3'd3: m_pending = (a != 0 || b != 0) ? 8'd1 : 8'd0;
               3'd4: m_pending = (a == 15 && b == 15) ? 8'd1 : 8'd0;
               3'd5: m_pending = 8'(a * 16 + b);
               3'd6: begin m_pending = 8'(a * b); m_rem = b + 1; end
               default: m_keep = 1;
            endcase
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge Clock) begin
      if (check_en) begin
         check("model ALUout", 32'(ALUout), 32'(m_alu));
         check("model Busy",   32'(Busy),   32'(m_rem > 0));
         check("model Done",   32'(Done),   32'(m_done));
      end
   end

   // Issue one op at a negedge; return at the negedge where Done is seen.
   task automatic do_op(input logic [3:0] d, input logic [2:0] f, input bit noise,
                        output int busy_n, output int done_n);
      bit finished = 0;
      busy_n = 0;
      done_n = 0;
      Data = d; Function = f; Go = 1'b1;
      @(posedge Clock);
      #1 Go = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         if (Busy) busy_n++;
         if (Done) begin
            done_n++;
            Go = 1'b0;
            finished = 1;
            break;
         end
         if (noise) begin
            Go       = 1'($urandom_range(0, 1));
            Data     = 4'($urandom);
            Function = 3'($urandom);
         end
      end
      if (!finished) begin
         n_checks++;
         $display("FAIL op timeout: got no Done, required Done within 40 cycles");
      end
   endtask

   initial begin
      int bn, dn;
      Reset = 1'b1; Go = 1'b0; Data = 4'h0; Function = 3'b000;
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
      check_en = 1;
      @(negedge Clock);
      check("reset ALUout", 32'(ALUout), 32'h00);
      check("reset Busy",   32'(Busy),   32'h0);
      check("reset Done",   32'(Done),   32'h0);

      // {A,B} with B=0 after reset
      do_op(4'h5, 3'b101, 0, bn, dn);
      check("op101 ALUout", 32'(ALUout), 32'h50);
      check("op101 busy cycles", 32'(bn), 32'd1);
      check("op101 done pulses", 32'(dn), 32'd1);

      // 0x50 -> 0x09 via truncated add (0+9)
      do_op(4'h9, 3'b001, 0, bn, dn);
      check("seed 09", 32'(ALUout), 32'h09);
      do_op(4'hF, 3'b000, 0, bn, dn);
      check("op000 9+F carry", 32'(ALUout), 32'h18);
      do_op(4'h1, 3'b001, 0, bn, dn);
      check("op001 8+1", 32'(ALUout), 32'h09);

      // (9+A)&F = 3, then 7*3 with noise while busy
      do_op(4'hA, 3'b001, 0, bn, dn);
      check("seed 03", 32'(ALUout), 32'h03);
      do_op(4'h7, 3'b110, 1, bn, dn);
      check("mul 7*3", 32'(ALUout), 32'h15);
      check("mul 7*3 busy cycles", 32'(bn), 32'd4);
      check("mul 7*3 done pulses", 32'(dn), 32'd1);

      // (5+A)&F = F, then F*F
      do_op(4'hA, 3'b001, 0, bn, dn);
      check("seed 0F", 32'(ALUout), 32'h0F);
      do_op(4'hF, 3'b110, 0, bn, dn);
      check("mul F*F", 32'(ALUout), 32'hE1);
      check("mul F*F busy cycles", 32'(bn), 32'd16);
      do_op(4'h0, 3'b010, 0, bn, dn);
      check("op010 B=1", 32'(ALUout), 32'h01);

      // Or/and corner values
      do_op(4'h0, 3'b011, 0, bn, dn);
      check("op011 0|1", 32'(ALUout), 32'h01);

      // (1+9)=A, then multiply aborted by reset on the 3rd MUL cycle
      do_op(4'h9, 3'b001, 0, bn, dn);
      check("seed 0A", 32'(ALUout), 32'h0A);
      Data = 4'h3; Function = 3'b110; Go = 1'b1;
      @(posedge Clock);
      #1 Go = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1 Reset = 1'b0;
      check("abort ALUout", 32'(ALUout), 32'h00);
      check("abort Busy",   32'(Busy),   32'h0);
      dn = 0;
      repeat (4) begin
         @(negedge Clock);
         if (Done) dn++;
      end
      check("abort no Done", 32'(dn), 32'd0);
      do_op(4'hF, 3'b100, 0, bn, dn);
      check("op100 F&0", 32'(ALUout), 32'h00);

      // B=0 multiply: one MUL cycle, result 0
      do_op(4'h9, 3'b110, 0, bn, dn);
      check("mul B=0 result", 32'(ALUout), 32'h00);
      check("mul B=0 busy cycles", 32'(bn), 32'd1);

      // 0+8 = 08, sign-extend to F8, then no-op keeps F8
      do_op(4'h8, 3'b001, 0, bn, dn);
      check("seed 08", 32'(ALUout), 32'h08);
      do_op(4'h0, 3'b010, 0, bn, dn);
      check("op010 sext 8", 32'(ALUout), 32'hF8);
      do_op(4'h3, 3'b111, 0, bn, dn);
      check("op111 hold", 32'(ALUout), 32'hF8);
      check("op111 done pulses", 32'(dn), 32'd1);

      repeat (3) @(negedge Clock);
      check_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire
